// File: rtl/dl_pkg.sv
// Shared types for the dl datapath: occupancy encoding of the skid buffer.
package dl_pkg;
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;
endpackage

// File: rtl/dl_reg_en.sv
// Enable-gated data register with synchronous active-high reset to zero.
module dl_reg_en #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_BITS-1:0] d,
  output logic [NUM_BITS-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry valid/ready skid buffer; ready/valid are decoded from state only.
// Optional DL_SKID_BUF_FLUSH_EN adds a flush input that empties the buffer.
module dl_skid_buf
  import dl_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef DL_SKID_BUF_FLUSH_EN
  input  logic                flush,
`endif
  output logic [NUM_BITS-1:0] out_data
);
  skid_state_t         state_q, state_d;
  logic                main_en, skid_en, main_from_skid;
  logic [NUM_BITS-1:0] skid_q, main_d;
  logic                in_fire, out_fire;

  assign out_valid = (state_q != SKID_EMPTY);
  assign in_ready  = (state_q != SKID_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign main_d    = main_from_skid ? skid_q : in_data;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      SKID_EMPTY: if (in_fire) begin
        main_en = 1'b1;
        state_d = SKID_BUSY;
      end
      SKID_BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = SKID_FULL;
        end else if (out_fire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: if (out_fire) begin
        main_en        = 1'b1;
        main_from_skid = 1'b1;
        state_d        = SKID_BUSY;
      end
      default: state_d = SKID_EMPTY;  // unused encoding recovers to empty
    endcase
`ifdef DL_SKID_BUF_FLUSH_EN
    // Flush drops both words and any concurrent input; data regs keep old values.
    if (flush) begin
      state_d = SKID_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SKID_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (state_q != skid_state_t'(2'd3));
  end

  dl_reg_en #(.NUM_BITS(NUM_BITS)) u_main (
    .clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(out_data)
  );

  dl_reg_en #(.NUM_BITS(NUM_BITS)) u_skid (
    .clk(clk), .rst(rst), .en(skid_en), .d(in_data), .q(skid_q)
  );
endmodule

// File: tb/tb_dl_skid_buf.sv
// Directed self-checking bench for dl_skid_buf.
module tb_dl_skid_buf;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_data, out_data;
  int total = 0;
  int bad   = 0;

  dl_skid_buf #(.NUM_BITS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef DL_SKID_BUF_FLUSH_EN
    .flush(flush),
`endif
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_data = 32'hDEAD_BEEF; out_ready = 1; flush = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov cyc=%0d got=%b exp=0", i, out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ir cyc=%0d got=%b exp=1", i, in_ready); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_od cyc=%0d got=%h exp=0", i, out_data); end
    end
    rst = 0; in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_post_ov got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_post_ir got=%b exp=1", in_ready); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_post_od got=%h exp=0", out_data); end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals = '{32'h1, 32'h2, 32'h3};
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      step();
      total++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin bad++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ir_%0d got=%b exp=1", i, in_ready); end
    end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b/%h/%b exp=1/a/1", out_valid, out_data, in_ready); end
    in_data = 32'hB;
    step();
    total++; if (in_ready !== 1'b0 || out_data !== 32'hA) begin bad++; $display("FAIL bp_full got=%b/%h exp=0/a", in_ready, out_data); end
    in_data = 32'hC;  // offered while full, must wait
    step();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin bad++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/a", in_ready, out_valid, out_data); end
    out_ready = 1;
    step();
    total++; if (out_data !== 32'hB || in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b exp=b/1", out_data, in_ready); end
    step();
    total++; if (out_data !== 32'hC || out_valid !== 1'b1) begin bad++; $display("FAIL bp_third got=%h/%b exp=c/1", out_data, out_valid); end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1; in_valid = 1; in_data = 32'h5;
    step();
    total++; if (out_data !== 32'h5 || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b exp=5/1", out_data, out_valid); end
    in_data = 32'h6;
    step();
    total++; if (out_data !== 32'h6 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=6/1", out_data, in_ready); end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 0; in_valid = 1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    total++; if (in_ready !== 1'b0 || out_data !== 32'h11) begin bad++; $display("FAIL mrst_full got=%b/%h exp=0/11", in_ready, out_data); end
    rst = 1; in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin bad++; $display("FAIL mrst_clear got=%b/%b/%h exp=0/1/0", out_valid, in_ready, out_data); end
    rst = 0; in_valid = 1; in_data = 32'h33; out_ready = 1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin bad++; $display("FAIL mrst_next got=%b/%h exp=1/33", out_valid, out_data); end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_alone got=%b/%h exp=0", out_valid, out_data); end
  endtask

`ifdef DL_SKID_BUF_FLUSH_EN
  task automatic test_flush();
    out_ready = 0; in_valid = 1; in_data = 32'h55;
    step();
    in_data = 32'h66;
    step();
    flush = 1; in_data = 32'h77;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b/%b exp=0/1", out_valid, in_ready); end
    flush = 0; in_data = 32'h88; out_ready = 1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h88) begin bad++; $display("FAIL flush_next got=%b/%h exp=1/88", out_valid, out_data); end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drain got=%b/%h exp=0", out_valid, out_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_back_to_back();
    test_mid_reset();
`ifdef DL_SKID_BUF_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
